// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: button conditioning, LFSR mole draw, scoring and game FSM.
// Optional `MOLE_MISS_PENALTY_EN`: a missed hit in PLAY decrements the score (saturating at 0).
module mole_game_ctrl #(
    parameter int unsigned MOLE_PERIOD     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5,
    parameter int unsigned MAX_SCORE       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [4:0] hit_btn,
    input  logic       timer_done,
    output logic [2:0] oval_select,
    output logic [3:0] score,
    output logic       pause,
    output logic       enable,
    output logic       game_start
);

    localparam int unsigned NumBtn = 7;
    localparam int unsigned DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned MoleW  = $clog2(MOLE_PERIOD);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [MoleW-1:0] MoleLast = MoleW'(MOLE_PERIOD - 1);
    localparam logic [3:0]       ScoreMax = 4'(MAX_SCORE);
    localparam logic [7:0]       SeedEff  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {StIdle, StPlay, StPause, StOver} state_e;

    state_e             state_q, state_d;
    logic [NumBtn-1:0]  sync1_q, sync2_q;
    logic [NumBtn-1:0]  db_lvl_q, db_lvl_d, db_prev_q;
    logic [DbW-1:0]     db_cnt_q [NumBtn];
    logic [DbW-1:0]     db_cnt_d [NumBtn];
    logic [7:0]         lfsr_q, lfsr_d;
    logic [MoleW-1:0]   mole_cnt_q, mole_cnt_d;
    logic [2:0]         oval_q, oval_d;
    logic [3:0]         score_q, score_d;
    logic               pause_q, pause_d;
    logic               enable_q, enable_d;
    logic               game_start_q, game_start_d;

    logic [NumBtn-1:0]  btn_rise;
    logic               start_edge, pause_edge, hit_edge, hit_ok, wrap;
    logic [4:0]         oval_mask;
    logic [2:0]         draw_raw, draw;

    // Bit 0 = start, bit 1 = pause, bits 6:2 = hit buttons.
    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn_rise   = db_lvl_q & ~db_prev_q;
    assign start_edge = btn_rise[0];
    assign pause_edge = btn_rise[1];
    assign hit_edge   = |btn_rise[6:2];

    assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign draw_raw  = 3'(lfsr_q % 8'd5) + 3'd1;
    // Re-draw by rotating 1..5 so the same oval never appears twice in a row.
    assign draw      = (draw_raw != oval_q) ? draw_raw :
                       (draw_raw == 3'd5)   ? 3'd1 : draw_raw + 3'd1;

    assign oval_mask = (oval_q == 3'd0) ? 5'd0 : 5'(5'b00001 << (oval_q - 3'd1));
    assign hit_ok    = hit_edge && (oval_mask != 5'd0) && (db_lvl_q[6:2] == oval_mask);
    assign wrap      = (mole_cnt_q == MoleLast);

    always_comb begin
        state_d      = state_q;
        oval_d       = oval_q;
        score_d      = score_q;
        mole_cnt_d   = mole_cnt_q;
        game_start_d = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start_edge) begin
                    state_d      = StPlay;
                    score_d      = 4'd0;
                    game_start_d = 1'b1;
                    oval_d       = draw;
                    mole_cnt_d   = '0;
                end
            end
            StPlay: begin
                if (timer_done) begin
                    state_d = StOver;
                    oval_d  = 3'd0;
                end else begin
                    mole_cnt_d = wrap ? '0 : mole_cnt_q + 1'b1;
                    if (hit_ok) begin
                        score_d = (score_q >= ScoreMax) ? ScoreMax : score_q + 4'd1;
                        oval_d  = 3'd0;
                    end
`ifdef MOLE_MISS_PENALTY_EN
                    else if (hit_edge && score_q != 4'd0) begin
                        score_d = score_q - 4'd1;
                    end
`endif
                    if (wrap) begin
                        oval_d = draw;
                    end
                    if (pause_edge) begin
                        state_d = StPause;
                    end
                end
            end
            StPause: begin
                if (timer_done) begin
                    state_d = StOver;
                    oval_d  = 3'd0;
                end else if (pause_edge) begin
                    state_d = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
        pause_d  = (state_d == StPause);
        enable_d = (state_d == StPlay) || (state_d == StPause);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sync1_q      <= '0;
            sync2_q      <= '0;
            db_lvl_q     <= '0;
            db_prev_q    <= '0;
            db_cnt_q     <= '{default: '0};
            lfsr_q       <= SeedEff;
            mole_cnt_q   <= '0;
            oval_q       <= 3'd0;
            score_q      <= 4'd0;
            pause_q      <= 1'b0;
            enable_q     <= 1'b0;
            game_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= {hit_btn, pause_btn, start_btn};
            sync2_q      <= sync1_q;
            db_lvl_q     <= db_lvl_d;
            db_prev_q    <= db_lvl_q;
            db_cnt_q     <= db_cnt_d;
            lfsr_q       <= lfsr_d;
            mole_cnt_q   <= mole_cnt_d;
            oval_q       <= oval_d;
            score_q      <= score_d;
            pause_q      <= pause_d;
            enable_q     <= enable_d;
            game_start_q <= game_start_d;
        end
    end

    assign oval_select = oval_q;
    assign score       = score_q;
    assign pause       = pause_q;
    assign enable      = enable_q;
    assign game_start  = game_start_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Scoreboard bench for mole_game_ctrl: expected output events are queued by the stimulus and
// consumed by a monitor whenever {game_start, score, pause, enable} changes or game_start pulses.
module tb_mole_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic [4:0] hit_btn = 5'd0;
    logic       timer_done = 1'b0;
    logic [2:0] oval_select;
    logic [3:0] score;
    logic       pause;
    logic       enable;
    logic       game_start;

    mole_game_ctrl #(
        .MOLE_PERIOD     (16),
        .DEBOUNCE_CYCLES (4),
        .LFSR_SEED       (8'hA5),
        .MAX_SCORE       (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .hit_btn     (hit_btn),
        .timer_done  (timer_done),
        .oval_select (oval_select),
        .score       (score),
        .pause       (pause),
        .enable      (enable),
        .game_start  (game_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       gs;
        logic [3:0] sc;
        logic       p;
        logic       en;
    } ev_t;

    ev_t exp_q[$];
    ev_t prev_ev = '0;
    int  n_cmp = 0;
    int  n_fail = 0;
    int  exp_score = 0;

    function automatic void push_ev(input logic gs, input int sc, input logic p, input logic en);
        ev_t e;
        e.gs = gs;
        e.sc = 4'(sc);
        e.p  = p;
        e.en = en;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: every observable output event must match the next queued expectation.
    always @(negedge clk) begin
        ev_t cur;
        ev_t e;
        cur = {game_start, score, pause, enable};
        if (cur !== prev_ev || cur.gs === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got gs=%0b score=%0d pause=%0b en=%0b, want none",
                         cur.gs, cur.sc, cur.p, cur.en);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_fail++;
                    $display("FAIL event: got gs=%0b score=%0d pause=%0b en=%0b, want gs=%0b score=%0d pause=%0b en=%0b",
                             cur.gs, cur.sc, cur.p, cur.en, e.gs, e.sc, e.p, e.en);
                end
            end
        end
        prev_ev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for a fresh nonzero mole (a wrap), returning right at the detecting negedge.
    task automatic wait_mole();
        logic [2:0] p;
        bit ok;
        ok = 1'b0;
        p = oval_select;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (oval_select !== p && oval_select != 3'd0) begin
                ok = 1'b1;
                break;
            end
            p = oval_select;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_mole: got no new mole in 40 cycles, want one");
        end
    endtask

    task automatic start_game(input string tag);
        push_ev(1'b1, 0, 1'b0, 1'b1);
        push_ev(1'b0, 0, 1'b0, 1'b1);
        exp_score = 0;
        @(negedge clk);
        start_btn = 1'b1;
        repeat (6) @(negedge clk);
        check({tag, "_gs_before"}, 32'(game_start), 0);
        @(negedge clk);
        check({tag, "_gs_at7"}, 32'(game_start), 1);
        check({tag, "_oval_range"}, 32'(oval_select >= 3'd1 && oval_select <= 3'd5), 1);
        @(negedge clk);
        check({tag, "_gs_one_cycle"}, 32'(game_start), 0);
        start_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // mode 0: correct bit, 1: wrong bit, 2: correct plus wrong bit.
    task automatic do_hit(input int mode, input string tag);
        logic [2:0] o;
        logic [4:0] good_m, bad_m;
        bit good;
        wait_mole();
        o = oval_select;
        good_m = 5'(5'b00001 << (o - 3'd1));
        bad_m  = 5'(5'b00001 << (o % 3'd5));
        good = (mode == 0);
        if (good) begin
            if (exp_score < 15) begin
                exp_score++;
                push_ev(1'b0, exp_score, 1'b0, 1'b1);
            end
        end else begin
`ifdef MOLE_MISS_PENALTY_EN
            if (exp_score > 0) begin
                exp_score--;
                push_ev(1'b0, exp_score, 1'b0, 1'b1);
            end
`endif
        end
        hit_btn = (mode == 0) ? good_m : (mode == 1) ? bad_m : (good_m | bad_m);
        repeat (7) @(negedge clk);
        if (good) check({tag, "_oval_cleared"}, 32'(oval_select), 0);
        else      check({tag, "_oval_kept"}, 32'(oval_select), 32'(o));
        @(negedge clk);
        if (good) check({tag, "_oval_stays_0"}, 32'(oval_select), 0);
        hit_btn = 5'd0;
    endtask

    task automatic press_pause(input logic want_pause);
        push_ev(1'b0, exp_score, want_pause, 1'b1);
        @(negedge clk);
        pause_btn = 1'b1;
        repeat (7) @(negedge clk);
        check("pause_level", 32'(pause), 32'(want_pause));
        @(negedge clk);
        pause_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        logic [2:0] p, o_frz;
        logic [3:0] s_frz;
        int last_chg, n_chg;
        bit seen;

        // 1: reset then idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_oval", 32'(oval_select), 0);
        check("idle_score", 32'(score), 0);
        check("idle_pause", 32'(pause), 0);
        check("idle_enable", 32'(enable), 0);
        check("idle_gs", 32'(game_start), 0);

        // 2: start game; moles change every 16 cycles, never repeat, never 0
        start_game("start");
        p = oval_select;
        last_chg = -1;
        n_chg = 0;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            if (oval_select !== p) begin
                check("mole_nonzero", 32'(oval_select != 3'd0), 1);
                check("mole_range", 32'(oval_select <= 3'd5), 1);
                if (last_chg >= 0) check("mole_period", 32'(t - last_chg), 16);
                last_chg = t;
                n_chg++;
            end
            p = oval_select;
        end
        check("mole_changes", 32'(n_chg >= 4), 1);

        // 3: hits, including saturation at 15
        for (int i = 0; i < 17; i++) do_hit(0, "hit");
        check("score_saturated", 32'(score), 15);

        // 4: misses
        do_hit(1, "miss_wrong");
        do_hit(2, "miss_two");
        check("score_after_miss", 32'(score), 32'(exp_score));

        // 5: pause freezes mole and score despite hits
        press_pause(1'b1);
        o_frz = oval_select;
        s_frz = score;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 2 || i == 25) hit_btn = (o_frz == 3'd0) ? 5'd1 : 5'(5'b00001 << (o_frz - 3'd1));
            if (i == 10 || i == 33) hit_btn = 5'd0;
            check("pause_oval_frozen", 32'(oval_select), 32'(o_frz));
            check("pause_score_frozen", 32'(score), 32'(s_frz));
        end
        press_pause(1'b0);
        seen = 1'b0;
        p = oval_select;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (oval_select !== p) seen = 1'b1;
            p = oval_select;
        end
        check("resume_mole_moves", 32'(seen), 1);

        // 6: timer_done wins over a simultaneous hit
        wait_mole();
        hit_btn = 5'(5'b00001 << (oval_select - 3'd1));
        repeat (6) @(negedge clk);
        timer_done = 1'b1;
        push_ev(1'b0, exp_score, 1'b0, 1'b0);
        @(negedge clk);
        check("over_oval", 32'(oval_select), 0);
        check("over_enable", 32'(enable), 0);
        check("over_score", 32'(score), 32'(exp_score));
        @(negedge clk);
        timer_done = 1'b0;
        hit_btn = 5'd0;
        repeat (12) @(negedge clk);
        check("over_score_held", 32'(score), 32'(exp_score));

        start_game("restart");
        check("restart_score", 32'(score), 0);

        // Short glitches must be filtered out
        @(negedge clk);
        pause_btn = 1'b1;
        hit_btn = (oval_select == 3'd0) ? 5'd1 : 5'(5'b00001 << (oval_select - 3'd1));
        start_btn = 1'b1;
        repeat (2) @(negedge clk);
        pause_btn = 1'b0;
        hit_btn = 5'd0;
        start_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_pause", 32'(pause), 0);
        check("glitch_score", 32'(score), 0);
        check("glitch_enable", 32'(enable), 1);

        // Mid-game reset
        push_ev(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_oval", 32'(oval_select), 0);
        check("rst_enable", 32'(enable), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
